// File: rtl/sips4_pkg.sv
// sips4_pkg: shared constants and loader state encoding for the SIPS4 program loader
package sips4_pkg;
  localparam int ADDR_W = 4;
  localparam int INSTR_W = 16;
  localparam logic [7:0] HEADER = 8'hA5;
  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CSUM, DONE, ERR} ld_state_e;
endpackage

// File: rtl/sips4_prog_loader.sv
// sips4_prog_loader: byte-stream framed loader that fills SIPS4 program memory and gates cpu_hold
module sips4_prog_loader
  import sips4_pkg::*;
#(
  parameter int ADDR_W = sips4_pkg::ADDR_W,
  parameter logic [7:0] HEADER = sips4_pkg::HEADER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pm_wen,
  output logic [ADDR_W-1:0] pm_waddr,
  output logic [15:0]       pm_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  ld_state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d, pm_waddr_q, pm_waddr_d;
  logic [7:0] sum_q, sum_d, hi_q, hi_d;
  logic [15:0] pm_wdata_q, pm_wdata_d;
  logic in_ready_q, in_ready_d, pm_wen_q, pm_wen_d;
  logic cpu_hold_q, cpu_hold_d, done_q, done_d, err_q, err_d;
  logic xfer;
  assign xfer = in_valid & in_ready_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    sum_d = sum_q;
    hi_d = hi_q;
    in_ready_d = 1'b1;
    pm_wen_d = 1'b0;
    pm_waddr_d = pm_waddr_q;
    pm_wdata_d = pm_wdata_q;
    cpu_hold_d = cpu_hold_q;
    done_d = done_q;
    err_d = err_q;
    if (xfer) begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (in_data == HEADER) begin
            state_d = COUNT;
            cpu_hold_d = 1'b1;
            done_d = 1'b0;
            err_d = 1'b0;
          end
        end
        COUNT: begin
          cnt_d = in_data[ADDR_W-1:0];
          addr_d = '0;
          sum_d = in_data;
          state_d = |(in_data >> ADDR_W) ? ERR : HI;
          err_d = |(in_data >> ADDR_W);
        end
        HI: begin
          hi_d = in_data;
          sum_d = sum_q + in_data;
          state_d = LO;
        end
        LO: begin
          // one-cycle stall while the assembled word is written
          pm_wen_d = 1'b1;
          pm_waddr_d = addr_q;
          pm_wdata_d = {hi_q, in_data};
          sum_d = sum_q + in_data;
          in_ready_d = 1'b0;
          addr_d = addr_q + 1'b1;
          state_d = (addr_q == cnt_q) ? CSUM : HI;
        end
        CSUM: begin
          state_d = (in_data == sum_q) ? DONE : ERR;
          done_d = (in_data == sum_q);
          err_d = (in_data != sum_q);
          cpu_hold_d = (in_data != sum_q);
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      sum_q <= '0;
      hi_q <= '0;
      in_ready_q <= 1'b0;
      pm_wen_q <= 1'b0;
      pm_waddr_q <= '0;
      pm_wdata_q <= '0;
      cpu_hold_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      sum_q <= sum_d;
      hi_q <= hi_d;
      in_ready_q <= in_ready_d;
      pm_wen_q <= pm_wen_d;
      pm_waddr_q <= pm_waddr_d;
      pm_wdata_q <= pm_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign in_ready = in_ready_q;
  assign pm_wen = pm_wen_q;
  assign pm_waddr = pm_waddr_q;
  assign pm_wdata = pm_wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_sips4_prog_loader.sv
// tb_sips4_prog_loader: directed vector table plus multi-cycle sequences for the program loader
module tb_sips4_prog_loader;
  logic clk = 0;
  logic rst = 1;
  logic [7:0] in_data = '0;
  logic in_valid = 0;
  logic in_ready, pm_wen, cpu_hold, done, err;
  logic [3:0] pm_waddr;
  logic [15:0] pm_wdata;
  int nchk = 0;
  int nfail = 0;
  int wr_cnt = 0;
  logic [15:0] mem [16];
  typedef struct {
    logic [7:0] b;
    logic wen;
    logic [3:0] waddr;
    logic [15:0] wdata;
    logic hold;
    logic dn;
    logic er;
  } vec_t;
  vec_t tq[$];
  sips4_prog_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .pm_wen(pm_wen), .pm_waddr(pm_waddr), .pm_wdata(pm_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );
  always #10 clk = ~clk;
  always @(negedge clk) begin
    if (pm_wen) begin
      mem[pm_waddr] = pm_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    logic ok;
    ok = 1'b0;
    repeat (gap) tick();
    in_data = b;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk($sformatf("accept %02h", b), {31'd0, ok}, 32'd1);
  endtask
  task automatic v(input logic [7:0] b, input logic wen, input logic [3:0] a, input logic [15:0] d,
                   input logic h, input logic dn, input logic er);
    vec_t t;
    t.b = b; t.wen = wen; t.waddr = a; t.wdata = d; t.hold = h; t.dn = dn; t.er = er;
    tq.push_back(t);
  endtask
  task automatic chk_status(input string nm, input logic h, input logic dn, input logic er);
    chk({nm, " hold"}, {31'd0, cpu_hold}, {31'd0, h});
    chk({nm, " done"}, {31'd0, done}, {31'd0, dn});
    chk({nm, " err"}, {31'd0, err}, {31'd0, er});
  endtask
  task automatic load16(input int gap);
    int base;
    logic [7:0] cs;
    for (int i = 0; i < 16; i++) mem[i] = 16'hDEAD;
    base = wr_cnt;
    cs = 8'h0F;
    send(8'hA5, gap);
    send(8'h0F, gap);
    for (int i = 0; i < 16; i++) begin
      send(8'h00, gap);
      send(8'(i), gap);
      cs = cs + 8'(i);
      chk($sformatf("g%0d w%0d wen", gap, i), {31'd0, pm_wen}, 32'd1);
      chk($sformatf("g%0d w%0d addr", gap, i), {28'd0, pm_waddr}, i);
      chk($sformatf("g%0d w%0d data", gap, i), {16'd0, pm_wdata}, i);
      chk($sformatf("g%0d w%0d stall", gap, i), {31'd0, in_ready}, 32'd0);
      tick();
      chk($sformatf("g%0d w%0d ready back", gap, i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("g%0d w%0d wen pulse", gap, i), {31'd0, pm_wen}, 32'd0);
    end
    send(cs, gap);
    chk_status($sformatf("g%0d full done", gap), 1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    chk($sformatf("g%0d write count", gap), wr_cnt - base, 32'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("g%0d mem%0d", gap, i), {16'd0, mem[i]}, i);
  endtask
  initial begin
    int base;
    v(8'h00, 0, 0, 0, 1, 0, 0);
    v(8'hFF, 0, 0, 0, 1, 0, 0);
    v(8'hA5, 0, 0, 0, 1, 0, 0);
    v(8'h00, 0, 0, 0, 1, 0, 0);
    v(8'h12, 0, 0, 0, 1, 0, 0);
    v(8'h34, 1, 0, 16'h1234, 1, 0, 0);
    v(8'h46, 0, 0, 0, 0, 1, 0);
    v(8'h00, 0, 0, 0, 0, 1, 0);
    v(8'hA5, 0, 0, 0, 1, 0, 0);
    v(8'h00, 0, 0, 0, 1, 0, 0);
    v(8'h12, 0, 0, 0, 1, 0, 0);
    v(8'h34, 1, 0, 16'h1234, 1, 0, 0);
    v(8'h47, 0, 0, 0, 1, 0, 1);
    v(8'hA5, 0, 0, 0, 1, 0, 0);
    v(8'h10, 0, 0, 0, 1, 0, 1);
    v(8'hA5, 0, 0, 0, 1, 0, 0);
    v(8'h01, 0, 0, 0, 1, 0, 0);
    v(8'hAB, 0, 0, 0, 1, 0, 0);
    v(8'hCD, 1, 0, 16'hABCD, 1, 0, 0);
    v(8'hA5, 0, 0, 0, 1, 0, 0);
    v(8'h5A, 1, 1, 16'hA55A, 1, 0, 0);
    v(8'h78, 0, 0, 0, 0, 1, 0);
    repeat (2) tick();
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst wen", {31'd0, pm_wen}, 32'd0);
    chk("rst waddr", {28'd0, pm_waddr}, 32'd0);
    chk("rst wdata", {16'd0, pm_wdata}, 32'd0);
    chk_status("rst", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk("ready after rst", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < tq.size(); i++) begin
      send(tq[i].b, 0);
      chk($sformatf("v%0d wen", i), {31'd0, pm_wen}, {31'd0, tq[i].wen});
      if (tq[i].wen) begin
        chk($sformatf("v%0d waddr", i), {28'd0, pm_waddr}, {28'd0, tq[i].waddr});
        chk($sformatf("v%0d wdata", i), {16'd0, pm_wdata}, {16'd0, tq[i].wdata});
      end
      chk($sformatf("v%0d ready", i), {31'd0, in_ready}, {31'd0, !tq[i].wen});
      chk_status($sformatf("v%0d", i), tq[i].hold, tq[i].dn, tq[i].er);
    end
    base = wr_cnt;
    send(8'hA5, 0);
    send(8'h10, 0);
    repeat (3) tick();
    chk("bad count no write", wr_cnt - base, 32'd0);
    load16(0);
    load16(2);
    send(8'hA5, 0);
    send(8'h03, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    tick();
    send(8'h33, 0);
    in_data = 8'h44;
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    chk("midrst in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst wen", {31'd0, pm_wen}, 32'd0);
    chk("midrst waddr", {28'd0, pm_waddr}, 32'd0);
    chk("midrst wdata", {16'd0, pm_wdata}, 32'd0);
    chk_status("midrst", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    in_valid = 1'b0;
    base = wr_cnt;
    send(8'h44, 1);
    send(8'h55, 0);
    repeat (3) tick();
    chk("post rst no write", wr_cnt - base, 32'd0);
    chk_status("post rst idle", 1'b1, 1'b0, 1'b0);
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    chk("post rst wdata", {16'd0, pm_wdata}, 32'h1234);
    send(8'h46, 0);
    chk_status("post rst reload", 1'b0, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/sips4_prog_loader.md
Name: sips4_prog_loader

Overview:
- Byte-stream program loader that writes the SIPS4 core's 16-word x 16-bit instruction memory.
- It is the writer side of the instruction-fetch port: the core only reads program memory by PC, and this block fills it.
- Holds the core in reset/stall via cpu_hold until a complete, checksum-valid image has been written; releases it afterwards.
- Sits between a byte source (UART receiver or host bridge) and the program-memory write port.

Parameters:
- ADDR_W, 4, program-memory address width (image length 1..2^ADDR_W words).
- HEADER, 8'hA5, start-of-frame byte.

Ports:
- clk  input  1  system clock (50MHz).
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data; transfer = in_valid & in_ready on rising clk.
- pm_wen  output  1  program-memory write enable, one-cycle pulse per word.
- pm_waddr  output  ADDR_W  program-memory write address.
- pm_wdata  output  16  instruction word.
- cpu_hold  output  1  keeps core PC frozen/reset while high.
- done  output  1  last load succeeded (level).
- err  output  1  last load failed (level).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- All outputs registered. Reset values: in_ready=0, pm_wen=0, pm_waddr=0, pm_wdata=0, cpu_hold=1, done=0, err=0, state=IDLE. in_ready=1 from the first cycle after rst deasserts, except as noted below.
- Frame format: HEADER, COUNT, then N words as hi byte followed by lo byte, then CSUM.
- COUNT encoding: N = COUNT[ADDR_W-1:0]+1. COUNT[7:ADDR_W] must be 0, otherwise go to ERR.
- CSUM: 8-bit modulo-256 sum of COUNT and all data bytes. HEADER is not included.
- States:
  - IDLE: accept any byte. Only HEADER advances to COUNT; other bytes are discarded silently.
  - COUNT: latch N-1 into remaining count, clear addr and sum, add COUNT to sum. Go to ERR if the high bits are nonzero, else HI.
  - HI: latch hi byte, add to sum, go to LO.
  - LO: on acceptance, next cycle drives pm_wen=1, pm_waddr=addr, pm_wdata={hi,lo} for exactly one cycle. in_ready=0 during that write cycle (one-cycle stall). addr increments after the write. Go to CSUM if the written word was word N, else HI.
  - CSUM: if byte equals sum, go to DONE (done=1, err=0, cpu_hold=0 on the following cycle). On mismatch, go to ERR (err=1, done=0, cpu_hold stays 1).
  - DONE: core runs. A HEADER byte re-enters COUNT with cpu_hold=1, done=0 in the cycle after acceptance. Other bytes are ignored.
  - ERR: behaves like IDLE (HEADER restarts and clears err); cpu_hold stays 1.
- cpu_hold rises in the cycle after any HEADER acceptance outside an active frame. It is never low while any pm_wen of the current frame is outstanding.
- Words already written before an error remain in memory. Correctness comes only from cpu_hold and err.
- Address wrap: N=2^ADDR_W writes addresses 0..2^ADDR_W-1; addr never wraps within one frame.
- HEADER value appearing inside a frame is treated as data (no resync).
- in_valid low mid-frame: state holds indefinitely, with no timeout.
- rst mid-frame: returns immediately to reset values; the partial image is abandoned; cpu_hold=1.
- rst has priority over a simultaneous byte transfer.

Decomposition:
- Shared package sips4_pkg: ADDR_W, instruction width (16), HEADER constant, loader state enum (IDLE, COUNT, HI, LO, CSUM, DONE, ERR).
- No sub-module needed; checksum accumulator and word assembler stay inline.

Test Plan:
- 1-word frame: bytes A5,00,12,34,46 -> one pm_wen pulse with addr 0, data 16'h1234; then done=1, err=0, cpu_hold=0.
- Full 16-word frame: COUNT=0F, words 0x0000..0x000F, correct CSUM -> 16 pulses at addr 0..15 in order, in_ready low exactly one cycle after each lo byte, then done=1.
- Bad checksum: A5,00,12,34,47 -> addr 0 written with 1234, then err=1, done=0, cpu_hold stays 1; following A5 clears err.
- Bad COUNT: A5,10 -> err=1 and no pm_wen. Garbage bytes 00,FF before A5 in IDLE -> ignored, no state change.
- Reload and reset: after successful load, send A5 -> cpu_hold=1, done=0 next cycle. Assert rst after the hi byte of word 2 -> all outputs return to reset values, no further pm_wen. Gaps in in_valid between bytes -> identical memory contents.
